// File: rtl/operand_token_fifo_pkg.sv
// Shared token types and control-field encodings for the operand token queue.
// OP0 / BYPASS both encode as zero, so a cleared entry reads back as a NOP.
package operand_token_fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int DEF_CTRL_W = 8;

    typedef enum logic [3:0] {
        IT_OP0    = 4'd0,
        IT_ALU    = 4'd1,
        IT_MUL    = 4'd2,
        IT_MEM    = 4'd3,
        IT_BRANCH = 4'd4
    } instr_type_e;

    typedef enum logic [3:0] {
        XU_BYPASS = 4'd0,
        XU_INT    = 4'd1,
        XU_FPU    = 4'd2,
        XU_LSU    = 4'd3
    } xu_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] opA;
        logic [DEF_DATA_W-1:0] opB;
        logic [DEF_DATA_W-1:0] opC;
        logic [DEF_DATA_W-1:0] npc;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_CTRL_W-1:0] ctrl;
    } op_token_t;

    function automatic logic [DEF_CTRL_W-1:0] pack_ctrl(input instr_type_e it, input xu_e xu);
        return {it, xu};
    endfunction

    function automatic void unpack_ctrl(input logic [DEF_CTRL_W-1:0] c,
                                        output instr_type_e it, output xu_e xu);
        it = instr_type_e'(c[7:4]);
        xu = xu_e'(c[3:0]);
    endfunction

endpackage

// File: rtl/operand_token_fifo_mem.sv
// Token storage ring: register array with async clear, one write port and a
// combinational read port.
module token_ring_mem
    import operand_token_fifo_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = op_token_t,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  T                 wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output T                 rdata_o
);

    T mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_token_fifo.sv
// Elastic operand token queue between register read and execute. Tokens whose
// stream tag no longer matches the current stream are discarded at the head.
module operand_token_fifo
    import operand_token_fifo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int CTRL_W    = 8,
    parameter bit SQUASH_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_opA,
    input  logic [DATA_W-1:0]          in_opB,
    input  logic [DATA_W-1:0]          in_opC,
    input  logic [DATA_W-1:0]          in_npc,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_opA,
    output logic [DATA_W-1:0]          out_opB,
    output logic [DATA_W-1:0]          out_opC,
    output logic [DATA_W-1:0]          out_npc,
    output logic [TAG_W-1:0]           out_tag,
    output logic [CTRL_W-1:0]          out_ctrl,
    input  logic                       flush,
    input  logic [TAG_W-1:0]           flush_tag,
    output logic                       drop,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] opA;
        logic [DATA_W-1:0] opB;
        logic [DATA_W-1:0] opC;
        logic [DATA_W-1:0] npc;
        logic [TAG_W-1:0]  tag;
        logic [CTRL_W-1:0] ctrl;
    } tok_t;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    tok_t             wtok, head;
    logic             push, pop, stale, nonempty;

    assign wtok = '{opA: in_opA, opB: in_opB, opC: in_opC, npc: in_npc,
                    tag: in_tag, ctrl: in_ctrl};

    token_ring_mem #(.DEPTH(DEPTH), .T(tok_t)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wtok),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Squash compares against the registered stream tag, so it takes effect
    // the cycle after a flush and also covers a token pushed alongside it.
    assign nonempty  = (count_q != '0);
    assign stale     = SQUASH_EN && nonempty && (head.tag != cur_tag_q);
    assign out_valid = nonempty && !stale;
    assign drop      = stale;
    assign in_ready  = (count_q != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign pop       = (out_valid && out_ready) || stale;
    assign count     = count_q;

    assign out_opA  = head.opA;
    assign out_opB  = head.opB;
    assign out_opC  = head.opC;
    assign out_npc  = head.npc;
    assign out_tag  = head.tag;
    assign out_ctrl = head.ctrl;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        cur_tag_d = cur_tag_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (SQUASH_EN && flush) cur_tag_d = flush_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            cur_tag_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            cur_tag_q <= cur_tag_d;
        end
    end

endmodule

// File: tb/tb_operand_token_fifo.sv
// Bench: a squashing instance and a pure-FIFO instance share stimulus; each is
// checked every cycle against a queue model plus directed literal checks.
module tb_operand_token_fifo;
    import operand_token_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_opA = '0, in_opB = '0, in_opC = '0, in_npc = '0;
    logic [3:0]  in_tag = '0, flush_tag = '0;
    logic [7:0]  in_ctrl = '0;

    logic        s_in_ready, s_out_valid, s_drop, p_in_ready, p_out_valid, p_drop;
    logic [31:0] s_opA, s_opB, s_opC, s_npc, p_opA, p_opB, p_opC, p_npc;
    logic [3:0]  s_tag, p_tag;
    logic [7:0]  s_ctrl, p_ctrl;
    logic [2:0]  s_count, p_count;

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    operand_token_fifo #(.DEPTH(DEPTH), .SQUASH_EN(1'b1)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_opA(in_opA), .in_opB(in_opB), .in_opC(in_opC), .in_npc(in_npc),
        .in_tag(in_tag), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_opA(s_opA), .out_opB(s_opB), .out_opC(s_opC), .out_npc(s_npc),
        .out_tag(s_tag), .out_ctrl(s_ctrl), .flush(flush), .flush_tag(flush_tag),
        .drop(s_drop), .count(s_count));

    operand_token_fifo #(.DEPTH(DEPTH), .SQUASH_EN(1'b0)) dut_pure (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_opA(in_opA), .in_opB(in_opB), .in_opC(in_opC), .in_npc(in_npc),
        .in_tag(in_tag), .in_ctrl(in_ctrl), .out_valid(p_out_valid), .out_ready(out_ready),
        .out_opA(p_opA), .out_opB(p_opB), .out_opC(p_opC), .out_npc(p_npc),
        .out_tag(p_tag), .out_ctrl(p_ctrl), .flush(flush), .flush_tag(flush_tag),
        .drop(p_drop), .count(p_count));

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    op_token_t sq[$], pq[$];
    logic [3:0] m_cur;

    function automatic op_token_t in_tok();
        op_token_t t;
        t.opA = in_opA; t.opB = in_opB; t.opC = in_opC; t.npc = in_npc;
        t.tag = in_tag; t.ctrl = in_ctrl;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq.delete(); pq.delete(); m_cur = '0;
        end else begin
            bit st, sp, spu, pp, ppu;
            op_token_t t;
            t   = in_tok();
            st  = (sq.size() != 0) && (sq[0].tag != m_cur);
            sp  = st || ((sq.size() != 0) && out_ready);
            spu = in_valid && (sq.size() != DEPTH);
            pp  = (pq.size() != 0) && out_ready;
            ppu = in_valid && (pq.size() != DEPTH);
            if (sp)  void'(sq.pop_front());
            if (spu) sq.push_back(t);
            if (pp)  void'(pq.pop_front());
            if (ppu) pq.push_back(t);
            if (flush) m_cur = flush_tag;
        end
    end

    task automatic cmp(input string nm, input int n, input op_token_t hd, input bit st,
                       input logic ir, input logic ov, input logic dr, input logic [2:0] cnt,
                       input op_token_t act);
        chk({nm, ".count"}, 160'(cnt), 160'(n));
        chk({nm, ".in_ready"}, 160'(ir), 160'(n != DEPTH));
        chk({nm, ".out_valid"}, 160'(ov), 160'((n != 0) && !st));
        chk({nm, ".drop"}, 160'(dr), 160'(st));
        if (n != 0) chk({nm, ".payload"}, 160'(act), 160'(hd));
    endtask

    always @(negedge clk) begin
        op_token_t sh, ph, sa, pa;
        bit sst;
        sh = (sq.size() != 0) ? sq[0] : '0;
        ph = (pq.size() != 0) ? pq[0] : '0;
        sst = (sq.size() != 0) && (sh.tag != m_cur);
        sa = '{opA: s_opA, opB: s_opB, opC: s_opC, npc: s_npc, tag: s_tag, ctrl: s_ctrl};
        pa = '{opA: p_opA, opB: p_opB, opC: p_opC, npc: p_npc, tag: p_tag, ctrl: p_ctrl};
        cmp("sq", sq.size(), sh, sst, s_in_ready, s_out_valid, s_drop, s_count, sa);
        cmp("pf", pq.size(), ph, 1'b0, p_in_ready, p_out_valid, p_drop, p_count, pa);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input logic [31:0] a, input logic [3:0] t);
        in_valid = v;
        in_opA   = a;
        in_opB   = $urandom; in_opC = $urandom; in_npc = $urandom;
        in_tag   = t;
        in_ctrl  = pack_ctrl(instr_type_e'(4'($urandom_range(0, 4))), xu_e'(4'($urandom_range(0, 3))));
    endtask

    initial begin
        logic [3:0] strm;
        strm = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // reset / idle
        chk("rst.out_valid", 160'(s_out_valid), 160'(0));
        chk("rst.in_ready", 160'(s_in_ready), 160'(1));
        chk("rst.count", 160'(s_count), 160'(0));
        chk("rst.drop", 160'(s_drop), 160'(0));
        chk("rst.payload", 160'({s_opA, s_opB, s_opC, s_npc, s_tag, s_ctrl}), 160'(0));

        // fill to full, refuse a fifth, then drain in order
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin set_in(1'b1, 32'(k), 4'd0); @(negedge clk); end
        chk("full.count", 160'(s_count), 160'(4));
        chk("full.in_ready", 160'(s_in_ready), 160'(0));
        set_in(1'b1, 32'd99, 4'd0);
        @(negedge clk);
        chk("full.hold.count", 160'(s_count), 160'(4));
        set_in(1'b0, 32'd0, 4'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain.opA", 160'(s_opA), 160'(k));
            chk("drain.valid", 160'(s_out_valid), 160'(1));
            @(negedge clk);
        end
        chk("drain.count", 160'(s_count), 160'(0));

        // streaming push+pop, one cycle latency, pointer wrap
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 32'(100 + k), 4'd0);
            @(negedge clk);
            chk("stream.count", 160'(s_count), 160'(1));
            chk("stream.opA", 160'(s_opA), 160'(100 + k));
        end
        set_in(1'b0, 32'd0, 4'd0);
        @(negedge clk);
        chk("stream.empty", 160'(s_count), 160'(0));

        // squash of A,B after flush while C (new tag) is pushed
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 4'd0); @(negedge clk);
        set_in(1'b1, 32'hB, 4'd0); @(negedge clk);
        set_in(1'b1, 32'hC, 4'd1); flush = 1'b1; flush_tag = 4'd1; @(negedge clk);
        set_in(1'b0, 32'd0, 4'd0); flush = 1'b0; out_ready = 1'b1;
        chk("sq.A.drop", 160'(s_drop), 160'(1));
        chk("sq.A.valid", 160'(s_out_valid), 160'(0));
        chk("sq.A.opA", 160'(s_opA), 160'(32'hA));
        chk("pf.A.opA", 160'({p_out_valid, p_opA}), 160'({1'b1, 32'hA}));
        @(negedge clk);
        chk("sq.B.drop", 160'({s_drop, s_opA}), 160'({1'b1, 32'hB}));
        chk("pf.B.opA", 160'({p_out_valid, p_opA}), 160'({1'b1, 32'hB}));
        @(negedge clk);
        chk("sq.C.issue", 160'({s_drop, s_out_valid, s_opA}), 160'({2'b01, 32'hC}));
        chk("pf.C.opA", 160'({p_out_valid, p_opA}), 160'({1'b1, 32'hC}));
        @(negedge clk);
        chk("sq.end.count", 160'(s_count), 160'(0));
        chk("pf.end.count", 160'(p_count), 160'(0));
        strm = 4'd1;

        // flush while full: four drops, in_ready back after the first
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin set_in(1'b1, 32'(32'h50 + k), 4'd1); @(negedge clk); end
        set_in(1'b0, 32'd0, 4'd0); flush = 1'b1; flush_tag = 4'd2; @(negedge clk);
        flush = 1'b0;
        chk("fl.1", 160'({s_drop, s_in_ready, s_count}), 160'({2'b10, 3'd4}));
        @(negedge clk);
        chk("fl.2", 160'({s_drop, s_in_ready, s_count}), 160'({2'b11, 3'd3}));
        @(negedge clk);
        @(negedge clk);
        chk("fl.4", 160'({s_drop, s_count}), 160'({1'b1, 3'd1}));
        @(negedge clk);
        chk("fl.done", 160'({s_drop, s_count}), 160'({1'b0, 3'd0}));
        chk("fl.pf.count", 160'(p_count), 160'(4));
        strm = 4'd2;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pf.drained", 160'(p_count), 160'(0));

        // randomized traffic with occasional stream switches
        for (int c = 0; c < 800; c++) begin
            set_in(($urandom % 4) != 0, $urandom,
                   ($urandom % 4 == 0) ? 4'($urandom_range(0, 3)) : strm);
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 12) == 0;
            flush_tag = 4'($urandom_range(0, 3));
            if (flush) strm = flush_tag;
            @(negedge clk);
        end
        flush = 1'b0;

        // reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin set_in(1'b1, 32'(k + 7), 4'd2); @(negedge clk); end
        set_in(1'b0, 32'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.s", 160'({s_count, s_out_valid, s_drop, s_opA}), 160'(0));
        chk("mrst.p", 160'({p_count, p_out_valid}), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 32'h77, 4'd0);
        @(negedge clk);
        set_in(1'b0, 32'd0, 4'd0);
        chk("mrst.tag0", 160'({s_out_valid, s_drop, s_opA}), 160'({2'b10, 32'h77}));
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
